// File: rtl/gen_target.sv
// Training-sample sequencer: streams the XOR dataset with encoded target pairs for N_EPOCH passes.
// Optional macro GEN_TARGET_SOFT_EN selects soft targets (HI = 0.9, LO = 0.1) instead of 1.0 / 0.0.
module gen_target #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int N_EPOCH    = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  output logic [DATA_WIDTH-1:0]          x1,
  output logic [DATA_WIDTH-1:0]          x2,
  output logic [DATA_WIDTH-1:0]          t_1,
  output logic [DATA_WIDTH-1:0]          t_2,
  output logic                           label,
  output logic                           s_valid,
  input  logic                           s_ready,
  output logic [1:0]                     sample_idx,
  output logic [$clog2(N_EPOCH+1)-1:0]   epoch_cnt,
  output logic                           busy,
  output logic                           done
);

  localparam int EW = $clog2(N_EPOCH + 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC_BITS;

`ifdef GEN_TARGET_SOFT_EN
  localparam int ONE_I = 1 << FRAC_BITS;
  localparam logic [DATA_WIDTH-1:0] HI = DATA_WIDTH'((9 * ONE_I + 5) / 10);
  localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'((ONE_I + 5) / 10);
`else
  localparam logic [DATA_WIDTH-1:0] HI = ONE;
  localparam logic [DATA_WIDTH-1:0] LO = '0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [EW-1:0]           epoch_q, epoch_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [DATA_WIDTH-1:0]   x1_q, x1_d, x2_q, x2_d, t1_q, t1_d, t2_q, t2_d;
  logic                    label_q, label_d;

  logic                    hs;
  logic [1:0]              next_idx;
  logic [EW-1:0]           epoch_next;

  // The ROM is pure index decode: bit 1 selects x1, bit 0 selects x2, label is their XOR.
  function automatic logic [DATA_WIDTH-1:0] feat(input logic b);
    return b ? ONE : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      epoch_q     <= '0;
      stop_pend_q <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      label_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      epoch_q     <= epoch_d;
      stop_pend_q <= stop_pend_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      label_q     <= label_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    epoch_d     = epoch_q;
    stop_pend_d = stop_pend_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    label_d     = label_q;
    hs          = (state_q == RUN) && s_ready;
    next_idx    = '0;
    epoch_next  = epoch_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          idx_d       = '0;
          epoch_d     = '0;
          stop_pend_d = 1'b0;
          x1_d        = '0;
          x2_d        = '0;
          t1_d        = HI;
          t2_d        = LO;
          label_d     = 1'b0;
        end
      end
      RUN: begin
        stop_pend_d = stop_pend_q | stop;
        if (hs) begin
          next_idx = idx_q + 2'd1;
          if (idx_q == 2'd3 && epoch_q != EW'(N_EPOCH))
            epoch_next = epoch_q + EW'(1);
          // Completing the final epoch takes priority over a pending stop.
          if (idx_q == 2'd3 && epoch_next == EW'(N_EPOCH)) begin
            state_d     = DONE;
            idx_d       = '0;
            epoch_d     = epoch_next;
            stop_pend_d = 1'b0;
            x1_d        = '0;
            x2_d        = '0;
            t1_d        = '0;
            t2_d        = '0;
            label_d     = 1'b0;
          end else if (stop_pend_q || stop) begin
            state_d     = IDLE;
            idx_d       = '0;
            epoch_d     = '0;
            stop_pend_d = 1'b0;
            x1_d        = '0;
            x2_d        = '0;
            t1_d        = '0;
            t2_d        = '0;
            label_d     = 1'b0;
          end else begin
            idx_d   = next_idx;
            epoch_d = epoch_next;
            x1_d    = feat(next_idx[1]);
            x2_d    = feat(next_idx[0]);
            label_d = ^next_idx;
            t1_d    = (^next_idx) ? LO : HI;
            t2_d    = (^next_idx) ? HI : LO;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_valid    = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign sample_idx = idx_q;
  assign epoch_cnt  = epoch_q;
  assign x1         = x1_q;
  assign x2         = x2_q;
  assign t_1        = t1_q;
  assign t_2        = t2_q;
  assign label      = label_q;

endmodule

// File: tb/tb_gen_target.sv
// Scoreboard bench for gen_target: directed runs push expected beats, a negedge monitor checks each handshake.
module tb_gen_target;

  localparam int DW = 16;
  localparam logic [DW-1:0] ONE = 16'h1000;
`ifdef GEN_TARGET_SOFT_EN
  localparam logic [DW-1:0] HI = 16'h0E66;
  localparam logic [DW-1:0] LO = 16'h019A;
`else
  localparam logic [DW-1:0] HI = 16'h1000;
  localparam logic [DW-1:0] LO = 16'h0000;
`endif

  logic          clk, rst_n, start, stop, s_ready;
  logic [DW-1:0] x1, x2, t_1, t_2;
  logic          label, s_valid, busy, done;
  logic [1:0]    sample_idx;
  logic [1:0]    epoch_cnt;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] x1, x2, t1, t2;
    logic          lbl;
  } beat_t;

  beat_t expQ[$];
  int    nVec  = 0;
  int    nMiss = 0;

  gen_target #(.DATA_WIDTH(16), .FRAC_BITS(12), .N_EPOCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .x1(x1), .x2(x2), .t_1(t_1), .t_2(t_2), .label(label),
    .s_valid(s_valid), .s_ready(s_ready), .sample_idx(sample_idx),
    .epoch_cnt(epoch_cnt), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic rdy);
    @(posedge clk);
    #1;
    start   = st;
    stop    = sp;
    s_ready = rdy;
  endtask

  // Hand-written dataset table: idx -> (x1, x2, label), targets from label.
  task automatic pushBeat(input int i);
    beat_t b;
    logic [DW-1:0] tx1[4];
    logic [DW-1:0] tx2[4];
    logic          tl[4];
    tx1 = '{16'h0000, 16'h0000, 16'h1000, 16'h1000};
    tx2 = '{16'h0000, 16'h1000, 16'h0000, 16'h1000};
    tl  = '{1'b0, 1'b1, 1'b1, 1'b0};
    b.idx = 2'(i);
    b.x1  = tx1[i];
    b.x2  = tx2[i];
    b.lbl = tl[i];
    b.t1  = tl[i] ? LO : HI;
    b.t2  = tl[i] ? HI : LO;
    expQ.push_back(b);
  endtask

  task automatic waitDone(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("beat_idx", {30'd0, sample_idx}, {30'd0, e.idx});
        checkOutput("beat_x1", {16'd0, x1}, {16'd0, e.x1});
        checkOutput("beat_x2", {16'd0, x2}, {16'd0, e.x2});
        checkOutput("beat_t1", {16'd0, t_1}, {16'd0, e.t1});
        checkOutput("beat_t2", {16'd0, t_2}, {16'd0, e.t2});
        checkOutput("beat_label", {31'd0, label}, {31'd0, e.lbl});
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; s_ready = 1'b0;
    #3;
    checkOutput("rst_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_t1", {16'd0, t_1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_idx", {30'd0, sample_idx}, 32'd0);
    checkOutput("idle_epoch", {30'd0, epoch_cnt}, 32'd0);
    checkOutput("idle_x1", {16'd0, x1}, 32'd0);
    checkOutput("idle_t2", {16'd0, t_2}, 32'd0);

    // Full run, two epochs, ready always high.
    for (int i = 0; i < 8; i++) pushBeat(i % 4);
    applyStimulus(1, 0, 1);
    @(negedge clk);
    checkOutput("valid_before_run", {31'd0, s_valid}, 32'd0);
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("run_valid", {31'd0, s_valid}, 32'd1);
      checkOutput("run_busy", {31'd0, busy}, 32'd1);
      applyStimulus(0, 0, 1);
    end
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("done_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("done_busy", {31'd0, busy}, 32'd0);
    checkOutput("done_epoch", {30'd0, epoch_cnt}, 32'd2);
    checkOutput("done_idx", {30'd0, sample_idx}, 32'd0);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("epoch_hold", {30'd0, epoch_cnt}, 32'd2);
    checkOutput("run1_drained", expQ.size(), 32'd0);

    // Backpressure on idx 2 for three cycles.
    for (int i = 0; i < 8; i++) pushBeat(i % 4);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, s_valid}, 32'd1);
      checkOutput("bp_idx", {30'd0, sample_idx}, 32'd2);
      checkOutput("bp_x1", {16'd0, x1}, {16'd0, ONE});
      checkOutput("bp_t2", {16'd0, t_2}, {16'd0, HI});
      if (k < 2) applyStimulus(0, 0, 0);
      else       applyStimulus(0, 0, 1);
    end
    @(negedge clk);
    checkOutput("bp_release_idx", {30'd0, sample_idx}, 32'd2);
    waitDone("bp_done_seen");
    checkOutput("bp_epoch", {30'd0, epoch_cnt}, 32'd2);
    checkOutput("bp_drained", expQ.size(), 32'd0);

    // Stop while idx 1 is stalled.
    pushBeat(0);
    pushBeat(1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("stop_hold_valid", {31'd0, s_valid}, 32'd1);
    checkOutput("stop_hold_idx", {30'd0, sample_idx}, 32'd1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("stop_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("stop_busy", {31'd0, busy}, 32'd0);
    checkOutput("stop_no_done", {31'd0, done}, 32'd0);
    checkOutput("stop_epoch", {30'd0, epoch_cnt}, 32'd0);
    checkOutput("stop_idx", {30'd0, sample_idx}, 32'd0);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("stop_no_done_later", {31'd0, done}, 32'd0);
    checkOutput("stop_drained", expQ.size(), 32'd0);

    // Start during RUN must not disturb the sequence.
    for (int i = 0; i < 8; i++) pushBeat(i % 4);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    waitDone("restart_done_seen");
    checkOutput("restart_epoch", {30'd0, epoch_cnt}, 32'd2);
    checkOutput("restart_drained", expQ.size(), 32'd0);

    // Start together with stop in IDLE: stop wins.
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("startstop_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("startstop_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a run.
    pushBeat(0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_idx", {30'd0, sample_idx}, 32'd0);
    checkOutput("arst_x1", {16'd0, x1}, 32'd0);
    checkOutput("arst_x2", {16'd0, x2}, 32'd0);
    checkOutput("arst_t1", {16'd0, t_1}, 32'd0);
    checkOutput("arst_t2", {16'd0, t_2}, 32'd0);
    checkOutput("arst_drained", expQ.size(), 32'd0);
    s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_arst_valid", {31'd0, s_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/gen_target.md
Name: gen_target

Overview:
- Training-sample sequencer for the backpropagation network. It performs the inverse of the output comparator: it encodes a class label into a two-output fixed-point target pair.
  - Class 0 (output 1 should win) -> t_1 high, t_2 low.
  - Class 1 -> t_1 low, t_2 high.
- For each sample it streams the input pair (x1, x2) and the target pair over a valid/ready interface to the forward/backward datapath.
- It iterates the built-in XOR dataset for a programmable number of epochs.

Parameters:
- DATA_WIDTH, 16, width of x1/x2/t_1/t_2; signed fixed point.
- FRAC_BITS, 12, fractional bits; ONE = 1 << FRAC_BITS (0x1000 at default).
- N_EPOCH, 1000, number of full passes over the dataset per start; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run when idle
- stop  in  1  single-cycle pulse; requests early termination
- x1  out  DATA_WIDTH  input feature 1 of current sample
- x2  out  DATA_WIDTH  input feature 2 of current sample
- t_1  out  DATA_WIDTH  target for output neuron 1
- t_2  out  DATA_WIDTH  target for output neuron 2
- label  out  1  class of current sample (0 or 1)
- s_valid  out  1  sample beat valid
- s_ready  in  1  downstream accepts beat
- sample_idx  out  2  index of current sample, 0..3
- epoch_cnt  out  $clog2(N_EPOCH+1)  completed epochs in current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when all epochs complete

Behaviour:
- Dataset ROM (index: x1, x2, label):
  - 0: 0, 0, 0
  - 1: 0, ONE, 1
  - 2: ONE, 0, 1
  - 3: ONE, ONE, 0
- Target encoding:
  - label 0 -> t_1 = HI, t_2 = LO.
  - label 1 -> t_1 = LO, t_2 = HI.
  - Default HI = ONE, LO = 0.
- Reset (rst_n low, asynchronous): state IDLE; s_valid, busy, done = 0; sample_idx, epoch_cnt = 0; x1, x2, t_1, t_2, label = 0.
- FSM states:
  - IDLE -> RUN on start (not stop) in the same cycle.
    - Sample 0 is presented with s_valid = 1 and busy = 1 in the next cycle (latency 1).
  - RUN: s_valid = 1. Outputs are held stable while s_valid && !s_ready.
    - On handshake (s_valid && s_ready), sample_idx increments mod 4. Next sample data is registered so that a new beat is presented in the following cycle. Throughput is 1 beat/cycle with s_ready held high.
    - Handshake on idx 3: epoch_cnt increments.
    - If the new epoch_cnt == N_EPOCH -> DONE.
  - DONE: s_valid = 0, busy = 0, done = 1 for exactly one cycle -> IDLE.
    - epoch_cnt retains N_EPOCH until the next start; sample_idx = 0.
- start in RUN or DONE: ignored.
- start on the same cycle as stop in IDLE: stop wins; stays IDLE.
- stop in RUN:
  - Latched into a pending flag.
  - The beat in flight is never withdrawn: s_valid stays high until its handshake completes.
  - After that handshake -> IDLE with s_valid = 0, busy = 0, no done pulse. sample_idx and epoch_cnt are cleared to 0.
  - If that handshake also completes the final epoch, the DONE path is taken (done pulses).
- stop in IDLE/DONE: no effect, not latched.
- Asynchronous reset mid-run: immediate return to reset values; the beat in flight is lost.
- epoch_cnt saturates at N_EPOCH; no wrap-around.

Optional Feature:
- Macro: GEN_TARGET_SOFT_EN.
- Defined: soft targets, avoiding sigmoid saturation.
  - HI = (9*ONE+5)/10.
  - LO = (ONE+5)/10.
  - Default values: HI = 3686 (0x0E66), LO = 410 (0x019A).
  - x1/x2 are unchanged.
- Undefined: HI = ONE, LO = 0. No soft-constant logic is synthesized.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, s_valid = 0, busy = 0.
- N_EPOCH = 2, start pulse, s_ready = 1 -> s_valid rises 1 cycle after start.
  - 8 consecutive beats, idx 0,1,2,3,0,1,2,3.
  - (x1, x2, t_1, t_2) for idx 1 = (0x0000, 0x1000, 0x0000, 0x1000).
  - For idx 3 = (0x1000, 0x1000, 0x1000, 0x0000).
  - done pulses the cycle after the 8th beat; epoch_cnt = 2.
- Backpressure: s_ready low for 3 cycles on idx 2 -> x1 = 0x1000, t_2 = 0x1000 held stable, s_valid held high, idx advances only on the handshake.
- stop asserted while s_ready = 0 on idx 1 -> beat stays valid. After s_ready = 1 for one cycle: s_valid = 0, busy = 0, no done, epoch_cnt = 0.
- start during RUN and start+stop in IDLE -> ignored; beat sequence unchanged / stays IDLE.
- With GEN_TARGET_SOFT_EN: idx 0 -> t_1 = 0x0E66, t_2 = 0x019A. Assert rst_n low mid-run -> outputs clear asynchronously.
